// File: rtl/pipe_reg_hs.sv
// Elastic valid/ready register pipeline: STAGES bubble-collapsing slices,
// optional input skid slice for a registered s_ready_o, synchronous flush.
module pipe_reg_hs #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           STAGES     = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
  parameter int unsigned           CUT_READY  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [DATA_WIDTH-1:0]         s_dat_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [DATA_WIDTH-1:0]         m_dat_o,
  output logic [$clog2(STAGES+2)-1:0]   occ_o
);

  localparam int unsigned OCC_W = $clog2(STAGES + 2);

  if (STAGES == 0) begin : g_bad_stages
    $error("pipe_reg_hs: STAGES must be at least 1");
  end

  logic [STAGES-1:0]     v_q, v_d;
  logic [DATA_WIDTH-1:0] d_q [STAGES];
  logic [DATA_WIDTH-1:0] d_d [STAGES];
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [STAGES:0]       rdy_c;
  logic                  src_v_c;
  logic [DATA_WIDTH-1:0] src_d_c;
  logic                  skid_v_d;

  // Ready chain: a stage can take a beat when empty or when its successor can.
  always_comb begin
    logic r;
    r             = m_ready_i;
    rdy_c[STAGES] = r;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      r        = ~v_q[k] | r;
      rdy_c[k] = r;
    end
  end

  if (CUT_READY != 0) begin : g_skid
    logic                  sv_q, sv_d;
    logic [DATA_WIDTH-1:0] sd_q, sd_d;

    // Skid captures a port beat stage 0 cannot take; it drains first, keeping order.
    always_comb begin
      sv_d = sv_q;
      sd_d = sd_q;
      if (flush_i) begin
        sv_d = 1'b0;
      end else if (sv_q) begin
        sv_d = ~rdy_c[0];
      end else if (s_valid_i && !rdy_c[0]) begin
        sv_d = 1'b1;
        sd_d = s_dat_i;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sv_q <= 1'b0;
        sd_q <= RESET_VAL;
      end else begin
        sv_q <= sv_d;
        sd_q <= sd_d;
      end
    end

    assign src_v_c   = sv_q | s_valid_i;
    assign src_d_c   = sv_q ? sd_q : s_dat_i;
    assign skid_v_d  = sv_d;
    assign s_ready_o = ~sv_q & ~flush_i;
  end else begin : g_noskid
    assign src_v_c   = s_valid_i;
    assign src_d_c   = s_dat_i;
    assign skid_v_d  = 1'b0;
    assign s_ready_o = rdy_c[0] & ~flush_i;
  end

  // Stage next-state: load from upstream, otherwise hand off or hold.
  always_comb begin
    logic                  up_v;
    logic [DATA_WIDTH-1:0] up_d;
    logic                  load;
    v_d   = '0;
    occ_d = OCC_W'(skid_v_d);
    up_v  = src_v_c;
    up_d  = src_d_c;
    load  = 1'b0;
    for (int k = 0; k < int'(STAGES); k++) begin
      load   = rdy_c[k] & up_v & ~flush_i;
      v_d[k] = ~flush_i & (load | (v_q[k] & ~rdy_c[k+1]));
      d_d[k] = load ? up_d : d_q[k];
      occ_d  = occ_d + OCC_W'(v_d[k]);
      up_v   = v_q[k];
      up_d   = d_q[k];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q   <= '0;
      occ_q <= '0;
      d_q   <= '{default: RESET_VAL};
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      d_q   <= d_d;
    end
  end

  assign m_valid_o = v_q[STAGES-1] & ~flush_i;
  assign m_dat_o   = d_q[STAGES-1];
  assign occ_o     = occ_q;

`ifndef SV_ASSRT_DISABLE
  a_ctrl_known: assert property (@(posedge clk_i) disable iff (rst_i)
    !$isunknown({s_valid_i, m_ready_i, flush_i}));

  a_s_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (s_valid_i && !s_ready_o) |=> (s_valid_i && $stable(s_dat_i)));

  // A flush may withdraw a stalled output beat.
  a_m_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (m_valid_o && !m_ready_i) |=> (flush_i || (m_valid_o && $stable(m_dat_o))));
`endif

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Directed bench for pipe_reg_hs: a 3-stage skid pipe (u_a) and a 2-stage
// combinational-ready pipe (u_b), plus a queue-checked random phase on u_a.
module tb_pipe_reg_hs;

  logic clk = 1'b0;
  logic rst;

  logic        a_flush, a_sv, a_sr, a_mv, a_mr;
  logic [31:0] a_sd, a_md;
  logic [2:0]  a_occ;
  logic        b_flush, b_sv, b_sr, b_mv, b_mr;
  logic [31:0] b_sd, b_md;
  logic [1:0]  b_occ;

  int total = 0;
  int bad   = 0;

  int fill_sr  [14] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
  int fill_occ [14] = '{0, 1, 2, 3, 4, 4, 4, 4, 3, 3, 3, 2, 1, 0};
  int fill_mv  [14] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int fill_md  [14] = '{0, 0, 0, 'hA0, 'hA0, 'hA0, 'hA0,
                        'hA0, 'hA1, 'hA2, 'hA3, 'hA4, 'hA5, 0};

  logic [31:0] q [$];

  always #5 clk = ~clk;

  pipe_reg_hs #(.DATA_WIDTH(32), .STAGES(3), .RESET_VAL(32'hDEADBEEF), .CUT_READY(1)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
    .s_valid_i(a_sv), .s_ready_o(a_sr), .s_dat_i(a_sd),
    .m_valid_o(a_mv), .m_ready_i(a_mr), .m_dat_o(a_md), .occ_o(a_occ)
  );

  pipe_reg_hs #(.DATA_WIDTH(32), .STAGES(2), .RESET_VAL(32'h0), .CUT_READY(0)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
    .s_valid_i(b_sv), .s_ready_o(b_sr), .s_dat_i(b_sd),
    .m_valid_o(b_mv), .m_ready_i(b_mr), .m_dat_o(b_md), .occ_o(b_occ)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic hold, acc, dl;
    rst = 1'b1;
    a_flush = 1'b0; a_sv = 1'b0; a_sd = '0; a_mr = 1'b0;
    b_flush = 1'b0; b_sv = 1'b0; b_sd = '0; b_mr = 1'b0;
    #1;
    chk("rst_a_mv", 32'(a_mv), 32'd0);
    chk("rst_a_md", a_md, 32'hDEADBEEF);
    chk("rst_a_occ", 32'(a_occ), 32'd0);
    chk("rst_b_md", b_md, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_a_sr", 32'(a_sr), 32'd1);
    chk("rst_b_sr", 32'(b_sr), 32'd1);
    tick();

    // bubble collapse on the combinational-ready pipe
    b_sv = 1'b1; b_sd = 32'h55; #1;
    chk("bub_sr0", 32'(b_sr), 32'd1);
    tick();
    b_sv = 1'b0; tick();
    b_sv = 1'b1; b_sd = 32'h66; #1;
    chk("bub_mv", 32'(b_mv), 32'd1);
    chk("bub_md", b_md, 32'h55);
    chk("bub_occ1", 32'(b_occ), 32'd1);
    chk("bub_sr1", 32'(b_sr), 32'd1);
    tick();
    b_sv = 1'b0; #1;
    chk("bub_occ2", 32'(b_occ), 32'd2);
    chk("bub_sr_full", 32'(b_sr), 32'd0);
    chk("bub_md_hold", b_md, 32'h55);
    tick();
    b_mr = 1'b1; #1;
    chk("bub_sr_comb", 32'(b_sr), 32'd1);
    tick();
    #1;
    chk("bub_md2", b_md, 32'h66);
    chk("bub_occ3", 32'(b_occ), 32'd1);
    tick();
    #1;
    chk("bub_mv_end", 32'(b_mv), 32'd0);
    chk("bub_occ_end", 32'(b_occ), 32'd0);
    b_mr = 1'b0;

    // streaming 0x1..0x10 through the 3-stage skid pipe
    a_mr = 1'b1;
    for (int i = 0; i < 19; i++) begin
      int eo;
      a_sv = (i < 16);
      a_sd = (i < 16) ? 32'(i + 1) : 32'h0;
      #1;
      eo = (i <= 16) ? ((i < 3) ? i : 3) : 19 - i;
      chk("strm_sr", 32'(a_sr), 32'd1);
      chk("strm_mv", 32'(a_mv), 32'(i >= 3));
      if (i >= 3) chk("strm_md", a_md, 32'(i - 2));
      chk("strm_occ", 32'(a_occ), 32'(eo));
      tick();
    end
    chk("strm_occ_end", 32'(a_occ), 32'd0);

    // backpressure fill then drain
    for (int i = 0; i < 14; i++) begin
      a_mr = (i >= 7);
      a_sv = (i < 10);
      a_sd = (i < 4) ? 32'(32'hA0 + i) : (i < 9) ? 32'hA4 : 32'hA5;
      #1;
      chk("fill_sr", 32'(a_sr), 32'(fill_sr[i]));
      chk("fill_occ", 32'(a_occ), 32'(fill_occ[i]));
      chk("fill_mv", 32'(a_mv), 32'(fill_mv[i]));
      if (fill_mv[i] != 0) chk("fill_md", a_md, 32'(fill_md[i]));
      tick();
    end

    // flush with three beats held
    a_mr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_sv = 1'b1; a_sd = 32'(32'hB0 + i); #1;
      chk("fl_sr", 32'(a_sr), 32'd1);
      tick();
    end
    a_sv = 1'b1; a_sd = 32'hB3; a_mr = 1'b1; a_flush = 1'b1; #1;
    chk("fl_sr_forced", 32'(a_sr), 32'd0);
    chk("fl_mv_forced", 32'(a_mv), 32'd0);
    chk("fl_occ_pre", 32'(a_occ), 32'd3);
    tick();
    a_flush = 1'b0; #1;
    chk("fl_occ_post", 32'(a_occ), 32'd0);
    chk("fl_mv_post", 32'(a_mv), 32'd0);
    chk("fl_sr_post", 32'(a_sr), 32'd1);
    chk("fl_md_held", a_md, 32'hB0);
    tick();
    a_sv = 1'b0; #1;
    chk("fl_occ_one", 32'(a_occ), 32'd1);
    tick();
    chk("fl_mv_lat", 32'(a_mv), 32'd0);
    tick();
    chk("fl_mv_next", 32'(a_mv), 32'd1);
    chk("fl_md_next", a_md, 32'hB3);
    tick();

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      a_sv = 1'b1; a_sd = 32'(32'hC0 + i); tick();
    end
    a_sd = 32'hC3; #1;
    chk("ar_mv_pre", 32'(a_mv), 32'd1);
    chk("ar_md_pre", a_md, 32'hC0);
    rst = 1'b1; #1;
    chk("ar_mv", 32'(a_mv), 32'd0);
    chk("ar_md", a_md, 32'hDEADBEEF);
    chk("ar_occ", 32'(a_occ), 32'd0);
    #1 rst = 1'b0; a_sv = 1'b0; #1;
    chk("ar_sr", 32'(a_sr), 32'd1);
    tick();
    a_sv = 1'b1; a_sd = 32'hE0; tick();
    a_sv = 1'b0; tick();
    tick();
    chk("ar_resume_mv", 32'(a_mv), 32'd1);
    chk("ar_resume_md", a_md, 32'hE0);
    tick();

    // random valid/ready with an in-order scoreboard
    hold = 1'b0;
    for (int c = 0; c < 620; c++) begin
      if (!hold) begin
        a_sv = (c < 600) ? 1'($urandom_range(0, 1)) : 1'b0;
        a_sd = $urandom;
      end
      a_mr = (c < 600) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("rnd_occ", 32'(a_occ), 32'(q.size()));
      acc = a_sv & a_sr;
      dl  = a_mv & a_mr;
      if (dl) begin
        chk("rnd_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) chk("rnd_md", a_md, q.pop_front());
      end
      if (acc) q.push_back(a_sd);
      hold = a_sv & ~acc;
      tick();
    end
    chk("rnd_hold_end", 32'(hold), 32'd0);
    chk("rnd_q_empty", 32'(q.size()), 32'd0);
    chk("rnd_occ_end", 32'(a_occ), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
